// File: rtl/mult_gen.sv
// mult_gen: pipelined, clock-enabled integer multiplier (MAC-cell multiply primitive).
// Computes the exact A_WIDTH+B_WIDTH product of A and B, signed or unsigned, and
// presents the slice full_product[P_LSB +: P_WIDTH] on P after LATENCY enabled edges.
//
// Ports:
//   CLK      in   1        rising-edge clock
//   ARESETN  in   1        asynchronous active-low reset, zeroes every stage
//   A        in   A_WIDTH  multiplicand
//   B        in   B_WIDTH  multiplier
//   CE       in   1        clock enable for every pipeline register
//   SCLR     in   1        synchronous clear, overrides CE
//   P        out  P_WIDTH  registered product slice
module mult_gen #(
  parameter int unsigned A_WIDTH = 4,
  parameter int unsigned B_WIDTH = 4,
  parameter int unsigned P_WIDTH = 4,
  parameter int unsigned P_LSB   = 0,
  parameter bit          SIGNED  = 1'b0,
  parameter int unsigned LATENCY = 3
) (
  input  logic               CLK,
  input  logic               ARESETN,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  input  logic               CE,
  input  logic               SCLR,
  output logic [P_WIDTH-1:0] P
);

  localparam int unsigned FULL_WIDTH = A_WIDTH + B_WIDTH;

  // Exact product: operands are extended to the full width first, so the low
  // FULL_WIDTH bits of an unsigned multiply equal the exact signed product.
  function automatic logic [FULL_WIDTH-1:0] full_mult(
    input logic [A_WIDTH-1:0] op_a,
    input logic [B_WIDTH-1:0] op_b
  );
    logic [FULL_WIDTH-1:0] a_ext;
    logic [FULL_WIDTH-1:0] b_ext;
    if (SIGNED) begin
      a_ext = {{B_WIDTH{op_a[A_WIDTH-1]}}, op_a};
      b_ext = {{A_WIDTH{op_b[B_WIDTH-1]}}, op_b};
    end else begin
      a_ext = {{B_WIDTH{1'b0}}, op_a};
      b_ext = {{A_WIDTH{1'b0}}, op_b};
    end
    return a_ext * b_ext;
  endfunction

  logic [A_WIDTH-1:0]    mul_a;
  logic [B_WIDTH-1:0]    mul_b;
  logic [FULL_WIDTH-1:0] prod_full;
  logic [P_WIDTH-1:0]    prod_slice;
  logic                  unused_prod;

  assign prod_full  = full_mult(mul_a, mul_b);
  assign prod_slice = prod_full[P_LSB +: P_WIDTH];
  // Bits outside the output slice are intentionally discarded.
  assign unused_prod = ^prod_full;

  if (LATENCY == 1) begin : g_lat1
    // Single output register fed straight from the ports.
    logic [P_WIDTH-1:0] p_q;

    assign mul_a = A;
    assign mul_b = B;

    always_ff @(posedge CLK or negedge ARESETN) begin
      if (!ARESETN) begin
        p_q <= '0;
      end else if (SCLR) begin
        p_q <= '0;
      end else if (CE) begin
        p_q <= prod_slice;
      end
    end

    assign P = p_q;
  end else begin : g_latn
    // Operand stage, then LATENCY-1 product stages; only the output slice is
    // carried past the multiplier since no other product bits reach P.
    localparam int unsigned PIPE_DEPTH = LATENCY - 1;
    localparam int unsigned PIPE_BITS  = PIPE_DEPTH * P_WIDTH;

    logic [A_WIDTH-1:0]   a_q;
    logic [B_WIDTH-1:0]   b_q;
    logic [PIPE_BITS-1:0] pipe_q;

    assign mul_a = a_q;
    assign mul_b = b_q;

    // Slot 0 takes the fresh product; the top slot is the output register.
    always_ff @(posedge CLK or negedge ARESETN) begin
      if (!ARESETN) begin
        a_q    <= '0;
        b_q    <= '0;
        pipe_q <= '0;
      end else if (SCLR) begin
        a_q    <= '0;
        b_q    <= '0;
        pipe_q <= '0;
      end else if (CE) begin
        a_q    <= A;
        b_q    <= B;
        pipe_q <= (pipe_q << P_WIDTH) | PIPE_BITS'(prod_slice);
      end
    end

    assign P = pipe_q[PIPE_BITS-1 -: P_WIDTH];
  end

endmodule

// File: tb/tb_mult_gen.sv
// Bench for mult_gen: four configurations driven together, a queue-based
// reference of accepted operands, and a scoreboard checked by a monitor.
module tb_mult_gen;

  logic       clk;
  logic       aresetn;
  logic       ce;
  logic       sclr;
  logic [3:0] a;
  logic [3:0] b;
  logic [5:0] a2;
  logic [4:0] b2;
  logic [3:0] p0;
  logic [7:0] p1;
  logic [4:0] p2;
  logic [3:0] p3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Default 4x4 unsigned, 4-bit P, latency 3
  mult_gen u_def (
    .CLK(clk), .ARESETN(aresetn), .A(a), .B(b), .CE(ce), .SCLR(sclr), .P(p0)
  );

  // Signed, full 8-bit product, latency 2
  mult_gen #(.P_WIDTH(8), .SIGNED(1'b1), .LATENCY(2)) u_sgn (
    .CLK(clk), .ARESETN(aresetn), .A(a), .B(b), .CE(ce), .SCLR(sclr), .P(p1)
  );

  // Signed 6x5, mid slice [7:3], latency 4
  mult_gen #(.A_WIDTH(6), .B_WIDTH(5), .P_WIDTH(5), .P_LSB(3), .SIGNED(1'b1),
             .LATENCY(4)) u_wide (
    .CLK(clk), .ARESETN(aresetn), .A(a2), .B(b2), .CE(ce), .SCLR(sclr), .P(p2)
  );

  // Unsigned high nibble, latency 1
  mult_gen #(.P_LSB(4), .LATENCY(1)) u_l1 (
    .CLK(clk), .ARESETN(aresetn), .A(a), .B(b), .CE(ce), .SCLR(sclr), .P(p3)
  );

  typedef struct {
    int p0;
    int p1;
    int p2;
    int p3;
  } res_t;

  typedef struct {
    int due;
    int e0;
    int e1;
    int e2;
    int e3;
  } exp_t;

  res_t hist[$];  // results of accepted operand pairs since the last clear
  exp_t sb[$];    // expected P values, keyed by the edge they follow

  // Arithmetic reference: interpret operands, multiply, take the bit slice.
  function automatic int ref_p(input int av, input int aw, input int bv, input int bw,
                               input bit sgn, input int pw, input int lsb);
    int x;
    int y;
    int prod;
    x = av;
    y = bv;
    if (sgn && x >= (1 << (aw - 1))) x = x - (1 << aw);
    if (sgn && y >= (1 << (bw - 1))) y = y - (1 << bw);
    prod = x * y;
    return (prod >>> lsb) & ((1 << pw) - 1);
  endfunction

  // A result reaches P once it and LATENCY-1 later pairs have been accepted.
  function automatic int expect_for(input int k);
    int   lat;
    res_t r;
    lat = (k == 0) ? 3 : (k == 1) ? 2 : (k == 2) ? 4 : 1;
    if (hist.size() < lat) return 0;
    r = hist[hist.size() - lat];
    case (k)
      0:       return r.p0;
      1:       return r.p1;
      2:       return r.p2;
      default: return r.p3;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int av, input int bv, input int a2v, input int b2v,
                      input bit cev, input bit sclrv, input bit rstnv = 1'b1,
                      input bit glitch = 1'b0);
    res_t r;
    exp_t e;
    @(negedge clk);
    aresetn = rstnv;
    a       = 4'(av);
    b       = 4'(bv);
    a2      = 6'(a2v);
    b2      = 5'(b2v);
    ce      = cev;
    sclr    = sclrv;
    if (!rstnv || sclrv) begin
      hist.delete();
    end else if (cev) begin
      r.p0 = ref_p(av & 15, 4, bv & 15, 4, 1'b0, 4, 0);
      r.p1 = ref_p(av & 15, 4, bv & 15, 4, 1'b1, 8, 0);
      r.p2 = ref_p(a2v & 63, 6, b2v & 31, 5, 1'b1, 5, 3);
      r.p3 = ref_p(av & 15, 4, bv & 15, 4, 1'b0, 4, 4);
      hist.push_back(r);
    end
    e.due = cyc + 1;
    e.e0  = expect_for(0);
    e.e1  = expect_for(1);
    e.e2  = expect_for(2);
    e.e3  = expect_for(3);
    sb.push_back(e);
    // Operand glitches well before the edge; only the settled value counts.
    if (glitch) begin
      b = 4'd3;
      #1 b = 4'd4;
      #1 b = 4'd1;
      #1 b = 4'd2;
      #1 b = 4'd3;
      #1 b = 4'(bv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_def"},  int'(p0), 0);
    check({tag, "_sgn"},  int'(p1), 0);
    check({tag, "_wide"}, int'(p2), 0);
    check({tag, "_l1"},   int'(p3), 0);
  endtask

  // Reset asserted mid-cycle, P must drop before any clock edge.
  task automatic async_reset();
    @(negedge clk);
    #3 aresetn = 1'b0;
    hist.delete();
    #1 check_all_zero("async_rst");
  endtask

  task automatic rand_step(input bit allow_sclr);
    step(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
         int'($urandom_range(0, 63)), int'($urandom_range(0, 31)),
         $urandom_range(0, 3) != 0, allow_sclr && ($urandom_range(0, 24) == 0));
  endtask

  // Monitor: compare every DUT output after each edge that has an expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check("p_def",  int'(p0), e.e0);
      check("p_sgn",  int'(p1), e.e1);
      check("p_wide", int'(p2), e.e2);
      check("p_l1",   int'(p3), e.e3);
    end
  end

  initial begin : stimulus
    int stream[4];
    int left;
    stream  = '{3, 4, 5, 1};
    aresetn = 1'b0;
    ce      = 1'b0;
    sclr    = 1'b0;
    a       = '0;
    b       = '0;
    a2      = '0;
    b2      = '0;

    #3 check_all_zero("in_reset");
    repeat (2) step(3, 2, 0, 0, 1'b1, 1'b0, 1'b0);

    // Clear with CE low, then hold operands with CE low: P stays 0
    step(3, 2, 0, 0, 1'b0, 1'b1);
    repeat (3) step(3, 2, 5, 7, 1'b0, 1'b0);

    // Basic multiply held
    repeat (6) step(3, 2, 5, 7, 1'b1, 1'b0);

    // Streaming and truncation: 9, C, F, 3
    foreach (stream[i]) step(3, stream[i], 40 + i, 3 * i, 1'b1, 1'b0);
    repeat (4) step(3, 1, 2, 30, 1'b1, 1'b0);

    // Glitching B settles at 5: only 0xF may emerge
    step(3, 5, 9, 9, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (4) step(3, 5, 9, 9, 1'b1, 1'b0);

    // CE stall mid-stream
    step(2, 3, 17, 4, 1'b1, 1'b0);
    step(5, 3, 33, 21, 1'b1, 1'b0);
    step(7, 7, 60, 11, 1'b0, 1'b0);
    step(1, 1, 1, 1, 1'b0, 1'b0);
    step(6, 2, 12, 19, 1'b1, 1'b0);
    repeat (4) step(4, 4, 3, 3, 1'b1, 1'b0);

    // SCLR with data in flight, simultaneous CE
    step(9, 9, 50, 25, 1'b1, 1'b0);
    step(7, 7, 44, 13, 1'b1, 1'b0);
    step(11, 13, 8, 8, 1'b1, 1'b1);
    repeat (5) step(2, 3, 6, 6, 1'b1, 1'b0);

    // Overflow and signed boundary: 0xF*0xF, then -1*3
    repeat (5) step(15, 15, 63, 31, 1'b1, 1'b0);
    repeat (5) step(15, 3, 32, 16, 1'b1, 1'b0);

    // Randomized traffic
    repeat (400) rand_step(1'b1);

    // Asynchronous reset mid-stream, then recovery
    async_reset();
    step(5, 5, 5, 5, 1'b1, 1'b0, 1'b0);
    repeat (100) rand_step(1'b1);

    // Drain with CE low, then confirm the scoreboard emptied
    repeat (6) step(0, 0, 0, 0, 1'b0, 1'b0);
    left = 20;
    while (sb.size() != 0 && left > 0) begin
      @(negedge clk);
      left--;
    end
    #1 check("sb_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
